// File: rtl/fft_stage_sequencer.sv
// Address/control sequencer for an in-place radix-2 DIT FFT.
// Walks LOG2N stages of N/2 butterflies and delays strobes/addresses to write-back.
module fft_stage_sequencer #(
   parameter int LOG2N    = 3,
   parameter int RD_LAT   = 1,
   parameter int BFLY_LAT = 2
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   output logic [LOG2N-1:0]                     rd_addr_a,
   output logic [LOG2N-1:0]                     rd_addr_b,
   output logic [((LOG2N > 1) ? LOG2N-1 : 1)-1:0] tw_addr,
   output logic                                 rd_en,
   output logic                                 bf_enable,
   output logic [LOG2N-1:0]                     wr_addr_a,
   output logic [LOG2N-1:0]                     wr_addr_b,
   output logic                                 wr_en,
   output logic [$clog2(LOG2N+1)-1:0]           stage,
   output logic                                 busy,
   output logic                                 done
);

   localparam int N     = 1 << LOG2N;
   localparam int HALFN = N / 2;
   localparam int LAT   = RD_LAT + BFLY_LAT;
   localparam int TWW   = (LOG2N > 1) ? LOG2N - 1 : 1;
   localparam int SW    = $clog2(LOG2N + 1);
   localparam int DW    = $clog2(LAT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [LOG2N-1:0] k_q, k_d;
   logic [SW-1:0]    stage_q, stage_d;
   logic [DW-1:0]    cnt_q, cnt_d;

   logic             issue;
   logic             last_k;
   logic             last_stage;
   logic             drain_end;
   logic [LOG2N-1:0] half;
   logic [LOG2N-1:0] hmask;
   logic [LOG2N-1:0] addr_a;
   logic [LOG2N-1:0] addr_b;
   logic [SW-1:0]    tw_sh;
   logic [TWW-1:0]   tw_val;

   logic             en_q [LAT];
   logic [LOG2N-1:0] wa_q [LAT];
   logic [LOG2N-1:0] wb_q [LAT];

   assign issue      = (state_q == S_ISSUE);
   assign last_k     = (k_q == LOG2N'(HALFN - 1));
   assign last_stage = (stage_q == SW'(LOG2N - 1));
   assign drain_end  = (cnt_q == DW'(LAT - 1));

   // Stage s pairs addresses differing only in bit s; k is split around that bit.
   always_comb begin
      half   = LOG2N'(1) << stage_q;
      hmask  = half - LOG2N'(1);
      addr_a = ((k_q >> stage_q) << (stage_q + SW'(1))) | (k_q & hmask);
      addr_b = addr_a + half;
      tw_sh  = SW'(LOG2N - 1) - stage_q;
      tw_val = TWW'((k_q & hmask) << tw_sh);
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      stage_d = stage_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ISSUE;
               k_d     = '0;
               stage_d = '0;
            end
         end
         S_ISSUE: begin
            k_d = k_q + LOG2N'(1);
            if (last_k) begin
               state_d = S_DRAIN;
               k_d     = '0;
               cnt_d   = '0;
            end
         end
         S_DRAIN: begin
            cnt_d = cnt_q + DW'(1);
            if (drain_end) begin
               if (last_stage) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ISSUE;
                  stage_d = stage_q + SW'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            stage_d = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         stage_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         stage_q <= stage_d;
         cnt_q   <= cnt_d;
      end
   end

   // Delay line runs every cycle so write-back drains on its own.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LAT; i++) begin
            en_q[i] <= 1'b0;
            wa_q[i] <= '0;
            wb_q[i] <= '0;
         end
      end else begin
         en_q[0] <= issue;
         wa_q[0] <= rd_addr_a;
         wb_q[0] <= rd_addr_b;
         for (int i = 1; i < LAT; i++) begin
            en_q[i] <= en_q[i-1];
            wa_q[i] <= wa_q[i-1];
            wb_q[i] <= wb_q[i-1];
         end
      end
   end

   assign rd_en     = issue;
   assign rd_addr_a = issue ? addr_a : '0;
   assign rd_addr_b = issue ? addr_b : '0;
   assign tw_addr   = issue ? tw_val : '0;
   assign bf_enable = en_q[RD_LAT-1];
   assign wr_en     = en_q[LAT-1];
   assign wr_addr_a = wa_q[LAT-1];
   assign wr_addr_b = wb_q[LAT-1];
   assign stage     = stage_q;
   assign busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
   assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: offset-based schedule model, literal
// address tables, end-to-end DFT through a RAM model, and random start/reset.
module tb_fft_stage_sequencer;

   localparam int LOG2N = 3;
   localparam int N     = 8;
   localparam int HN    = 4;
   localparam int RDL   = 1;
   localparam int LAT   = 3;
   localparam int P     = HN + LAT;
   localparam int TOT   = LOG2N * P;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
   logic [1:0] tw_addr, stage;
   logic       rd_en, bf_enable, wr_en, busy, done;

   fft_stage_sequencer #(.LOG2N(3), .RD_LAT(1), .BFLY_LAT(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .tw_addr(tw_addr), .rd_en(rd_en), .bf_enable(bf_enable),
      .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b), .wr_en(wr_en),
      .stage(stage), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_r(input string nm, input real act, input real exp);
      real d;
      checks++;
      d = act - exp;
      if (d < 0.0) d = -d;
      if (d > 1.0e-3) begin
         failures++;
         $display("FAIL %s: got %f expected %f", nm, act, exp);
      end
   endtask

   // Reference: n-th address of stage s with bit s clear, in ascending order.
   function automatic int pair_a(input int s, input int k);
      int cnt, res;
      cnt = 0;
      res = -1;
      for (int a = 0; a < N; a++) begin
         if (((a >> s) & 1) == 0) begin
            if (cnt == k) res = a;
            cnt++;
         end
      end
      return res;
   endfunction

   function automatic int twid(input int s, input int a);
      return (a % (1 << s)) * (N >> (s + 1));
   endfunction

   function automatic bit is_rd(input int o);
      return (o >= 0) && (o < TOT) && ((o % P) < HN);
   endfunction

   function automatic int all_outs();
      return int'({rd_en, bf_enable, wr_en, busy, done, rd_addr_a,
                   rd_addr_b, tw_addr, stage, wr_addr_a, wr_addr_b});
   endfunction

   // Model: cycle offset from first rd_en of the running transform, -1 if idle.
   int off = -1;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) off = -1;
      else if (off < 0) begin
         if (start) off = 0;
      end else if (off == TOT) off = -1;
      else off = off + 1;
   end

   always @(negedge clk) begin
      int s, a, w;
      if (off < 0) begin
         chk("idle_outs", all_outs(), 0);
      end else begin
         chk("busy", int'(busy), int'(off < TOT));
         chk("done", int'(done), int'(off == TOT));
         chk("rd_en", int'(rd_en), int'(is_rd(off)));
         if (is_rd(off)) begin
            s = off / P;
            a = pair_a(s, off % P);
            chk("rd_addr_a", int'(rd_addr_a), a);
            chk("rd_addr_b", int'(rd_addr_b), a + (1 << s));
            chk("tw_addr", int'(tw_addr), twid(s, a));
            chk("stage", int'(stage), s);
         end
         chk("bf_enable", int'(bf_enable), int'(is_rd(off - RDL)));
         chk("wr_en", int'(wr_en), int'(is_rd(off - LAT)));
         if (is_rd(off - LAT)) begin
            s = (off - LAT) / P;
            w = pair_a(s, (off - LAT) % P);
            chk("wr_addr_a", int'(wr_addr_a), w);
            chk("wr_addr_b", int'(wr_addr_b), w + (1 << s));
         end
      end
   end

   // Capture for directed literal checks and the in-place RAM model.
   bit  cap_on = 1'b0;
   int  cyc = 0;
   int  first_rd = -1;
   int  done_cyc = -1;
   int  done_cnt = 0;
   int  seq[$];
   int  twq[$];
   real re[N];
   real im[N];

   always @(negedge clk) begin
      int  t;
      real ar, ai, br, bi, c, sn, tr, ti;
      cyc++;
      if (cap_on) begin
         if (rd_en) begin
            if (first_rd < 0) first_rd = cyc;
            seq.push_back(int'(rd_addr_a) * 100 + int'(rd_addr_b) * 10 + int'(tw_addr));
            twq.push_back(int'(tw_addr));
         end
         if (wr_en && twq.size() > 0) begin
            t  = twq.pop_front();
            c  = $cos(2.0 * 3.14159265358979 * t / N);
            sn = -$sin(2.0 * 3.14159265358979 * t / N);
            ar = re[wr_addr_a]; ai = im[wr_addr_a];
            br = re[wr_addr_b]; bi = im[wr_addr_b];
            tr = br * c - bi * sn;
            ti = br * sn + bi * c;
            re[wr_addr_a] = ar + tr; im[wr_addr_a] = ai + ti;
            re[wr_addr_b] = ar - tr; im[wr_addr_b] = ai - ti;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic clear_cap();
      cap_on = 1'b1;
      first_rd = -1;
      done_cyc = -1;
      done_cnt = 0;
      seq.delete();
      twq.delete();
   endtask

   int  exp_seq[12] = '{10, 230, 450, 670, 20, 132, 460, 572, 40, 151, 262, 373};
   int  x[N];
   real xr, xi;
   int  br3;

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Transform 1: literal address tables, timing and DFT result.
      for (int n = 0; n < N; n++) begin
         x[n] = int'($urandom_range(2000)) - 1000;
         br3 = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
         re[br3] = real'(x[n]);
         im[br3] = 0.0;
      end
      clear_cap();
      #2 start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
      repeat (30) @(posedge clk);
      chk("seq_len", seq.size(), 12);
      for (int i = 0; i < 12; i++)
         chk("seq_lit", (i < seq.size()) ? seq[i] : -1, exp_seq[i]);
      chk("done_latency", done_cyc - first_rd, 21);
      chk("done_count", done_cnt, 1);
      for (int k = 0; k < N; k++) begin
         xr = 0.0;
         xi = 0.0;
         for (int n = 0; n < N; n++) begin
            xr += x[n] * $cos(2.0 * 3.14159265358979 * n * k / N);
            xi -= x[n] * $sin(2.0 * 3.14159265358979 * n * k / N);
         end
         chk_r("bin_re", re[k], xr);
         chk_r("bin_im", im[k], xi);
      end

      // Transform 2: start re-pulsed in ISSUE, DRAIN and DONE is ignored.
      clear_cap();
      for (int i = 0; i < 32; i++) begin
         @(posedge clk);
         #2 start = (i == 0) || (i == 3) || (i == 6) || (i == 22);
      end
      start = 1'b0;
      repeat (4) @(posedge clk);
      chk("t5_seq_len", seq.size(), 12);
      chk("t5_done_count", done_cnt, 1);

      // Transform 3: reset mid-ISSUE aborts with no write or done.
      clear_cap();
      @(posedge clk);
      #2 start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk("async_reset_outs", all_outs(), 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (30) @(posedge clk);
      chk("t1_done_count", done_cnt, 0);
      cap_on = 1'b0;

      // Random start pulses and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #2;
         start = ($urandom_range(9) == 0);
         rst_n = ($urandom_range(199) != 0);
      end
      start = 1'b0;
      rst_n = 1'b1;
      repeat (30) @(posedge clk);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
